// File: rtl/conv_pkg.sv
// Shared types and sizing for the convolution MAC sequencer.
package conv_pkg;

    localparam int N_DEF     = 18;
    localparam int KSIZE_DEF = 3;
    localparam int TAPS      = KSIZE_DEF * KSIZE_DEF;
    localparam int ACC_EXTRA = 10;
    localparam int ACC_W     = N_DEF + ACC_EXTRA;

    typedef enum logic [1:0] {
        LOAD,
        RUN,
        DRAIN,
        DONE
    } state_t;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int TAP_W = idx_width(TAPS);

endpackage

// File: rtl/conv_weight_regfile.sv
// Kernel weight storage: one write port, one asynchronous read port.
module conv_weight_regfile
    import conv_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DEPTH = TAPS,
    parameter int AW    = idx_width(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [N-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [N-1:0]  rdata
);

    logic [N-1:0] mem [DEPTH];

    // Contents survive reset; the sequencer forces a reload instead.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/conv_mac_sequencer.sv
// Streams one convolution window per result through an external registered MAC,
// feeding its output back as the addend and returning the window sum.
module conv_mac_sequencer
    import conv_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int KSIZE = KSIZE_DEF
) (
    input  logic                   clk,
    input  logic                   sclr,
    input  logic                   w_valid,
    input  logic [N-1:0]           w_data,
    output logic                   w_ready,
    input  logic                   reload,
    input  logic                   px_valid,
    input  logic [N-1:0]           px_data,
    output logic                   px_ready,
    output logic [N-1:0]           mac_a,
    output logic [N-1:0]           mac_b,
    output logic [N-1:0]           mac_c,
    input  logic [N+ACC_EXTRA-1:0] mac_p,
    output logic                   res_valid,
    output logic [N+ACC_EXTRA-1:0] res_data,
    output logic                   res_ovf,
    input  logic                   res_ready,
    output logic                   busy
);

    localparam int NT = KSIZE * KSIZE;
    localparam int AW = N + ACC_EXTRA;
    localparam int TW = idx_width(NT);
    localparam logic [TW-1:0] LAST = TW'(NT - 1);

    state_t         state, state_n;
    logic [TW-1:0]  tap, tap_n;
    logic [TW-1:0]  widx, widx_n;
    logic [AW-1:0]  res_data_n;
    logic           res_ovf_n;
    logic           w_we;
    logic [N-1:0]   w_rd;

    conv_weight_regfile #(
        .N     (N),
        .DEPTH (NT),
        .AW    (TW)
    ) u_weights (
        .clk   (clk),
        .we    (w_we),
        .waddr (widx),
        .wdata (w_data),
        .raddr (tap),
        .rdata (w_rd)
    );

    always_ff @(posedge clk or posedge sclr) begin
        if (sclr) begin
            state    <= LOAD;
            tap      <= '0;
            widx     <= '0;
            res_data <= '0;
            res_ovf  <= 1'b0;
        end else begin
            state    <= state_n;
            tap      <= tap_n;
            widx     <= widx_n;
            res_data <= res_data_n;
            res_ovf  <= res_ovf_n;
        end
    end

    always_comb begin
        state_n    = state;
        tap_n      = tap;
        widx_n     = widx;
        res_data_n = res_data;
        res_ovf_n  = res_ovf;
        w_ready    = 1'b0;
        w_we       = 1'b0;
        px_ready   = 1'b0;
        mac_a      = '0;
        mac_b      = '0;
        mac_c      = '0;
        unique case (state)
            LOAD: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    w_we = 1'b1;
                    if (widx == LAST) begin
                        state_n = RUN;
                        widx_n  = '0;
                        tap_n   = '0;
                    end else begin
                        widx_n = widx + 1'b1;
                    end
                end
            end
            RUN: begin
                if (reload && tap == '0) begin
                    state_n = LOAD;
                    widx_n  = '0;
                end else begin
                    px_ready = 1'b1;
                    // Accumulator lives in the MAC; recirculate it even on bubbles.
                    if (tap != '0) begin
                        mac_c = mac_p[N-1:0];
                        if (mac_p[N]) begin
                            res_ovf_n = 1'b1;
                        end
                    end
                    if (px_valid) begin
                        mac_a = px_data;
                        mac_b = w_rd;
                        if (tap == '0) begin
                            res_ovf_n = 1'b0;
                        end
                        if (tap == LAST) begin
                            state_n = DRAIN;
                            tap_n   = '0;
                        end else begin
                            tap_n = tap + 1'b1;
                        end
                    end
                end
            end
            DRAIN: begin
                res_data_n = mac_p;
                state_n    = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    state_n = RUN;
                end
            end
            default: state_n = LOAD;
        endcase
    end

    assign res_valid = (state == DONE);
    assign busy      = (state == RUN && tap != '0)
                     || state == DRAIN || state == DONE;

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Scoreboard bench for conv_mac_sequencer with a behavioural registered MAC.
module tb_conv_mac_sequencer;
    import conv_pkg::*;

    localparam int N  = 18;
    localparam int AW = N + ACC_EXTRA;
    localparam int NT = 9;

    logic          clk = 1'b0;
    logic          sclr;
    logic          w_valid, w_ready, reload;
    logic [N-1:0]  w_data;
    logic          px_valid, px_ready;
    logic [N-1:0]  px_data;
    logic [N-1:0]  mac_a, mac_b, mac_c;
    logic [AW-1:0] mac_p;
    logic          res_valid, res_ovf, res_ready, busy;
    logic [AW-1:0] res_data;

    always #5 clk = ~clk;

    conv_mac_sequencer #(.N(N), .KSIZE(3)) dut (
        .clk       (clk),
        .sclr      (sclr),
        .w_valid   (w_valid),
        .w_data    (w_data),
        .w_ready   (w_ready),
        .reload    (reload),
        .px_valid  (px_valid),
        .px_data   (px_data),
        .px_ready  (px_ready),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_c     (mac_c),
        .mac_p     (mac_p),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ovf   (res_ovf),
        .res_ready (res_ready),
        .busy      (busy)
    );

    // Registered MAC: p = (a*b mod 2^N) + c, one cycle after a/b/c
    logic [N-1:0]   ra, rb, rc;
    logic [2*N-1:0] rprod;
    always_ff @(posedge clk or posedge sclr) begin
        if (sclr) begin
            ra <= '0;
            rb <= '0;
            rc <= '0;
        end else begin
            ra <= mac_a;
            rb <= mac_b;
            rc <= mac_c;
        end
    end
    assign rprod = ra * rb;
    assign mac_p = AW'(rprod[N-1:0]) + AW'(rc);

    typedef struct packed {
        logic [AW-1:0] data;
        logic          ovf;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           failures = 0;
    logic [N-1:0] wts [NT];
    logic [N-1:0] pix [NT];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model();
        exp_t           e;
        logic [AW-1:0]  full;
        logic [2*N-1:0] p;
        full  = '0;
        e.ovf = 1'b0;
        for (int i = 0; i < NT; i++) begin
            p = pix[i] * wts[i];
            if (i > 0 && full[N]) e.ovf = 1'b1;
            if (i == 0) full = AW'(p[N-1:0]);
            else full = AW'(p[N-1:0]) + AW'(full[N-1:0]);
        end
        e.data = full;
        return e;
    endfunction

    always @(negedge clk) begin
        if (res_valid && res_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("res_data", res_data, e.data);
                check("res_ovf", res_ovf, e.ovf);
            end
        end
    end

    task automatic load_one(input int i);
        logic got;
        got = 1'b0;
        w_valid = 1'b1;
        w_data  = wts[i];
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = w_ready;
            @(posedge clk);
            #1;
        end
        w_valid = 1'b0;
        if (!got) check("w_timeout", 0, 1);
    endtask

    task automatic send_pixels(input int n, input bit gap);
        logic got;
        for (int i = 0; i < n; i++) begin
            got = 1'b0;
            px_valid = 1'b1;
            px_data  = pix[i];
            for (int k = 0; k < 50 && !got; k++) begin
                @(negedge clk);
                got = px_ready;
                @(posedge clk);
                #1;
            end
            px_valid = 1'b0;
            if (!got) check("px_timeout", 0, 1);
            if (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic send_window(input bit gap);
        sb.push_back(model());
        send_pixels(NT, gap);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 100 && sb.size() != 0; k++) begin
            @(negedge clk);
        end
        check("drain_left", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [N-1:0] w);
        for (int i = 0; i < NT; i++) wts[i] = w;
    endtask

    task automatic set_ramp();
        for (int i = 0; i < NT; i++) pix[i] = N'(i + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "timeout");
    end

    initial begin
        sclr = 1'b1;
        w_valid = 1'b0;
        w_data = '0;
        reload = 1'b0;
        px_valid = 1'b0;
        px_data = '0;
        res_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_w_ready", w_ready, 1);
        check("rst_px_ready", px_ready, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        sclr = 1'b0;

        // contiguous window with latency check
        set_all(1);
        for (int i = 0; i < NT; i++) load_one(i);
        set_ramp();
        res_ready = 1'b0;
        send_window(0);
        @(negedge clk);
        check("lat_t1_valid", res_valid, 0);
        @(negedge clk);
        check("lat_t2_valid", res_valid, 1);
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        wait_drain();

        // bubbles
        send_window(1);
        wait_drain();

        // overflow
        for (int i = 0; i < NT; i++) pix[i] = '0;
        pix[0] = 18'h3FFFF;
        pix[1] = 18'h3FFFF;
        send_window(0);
        wait_drain();

        // backpressure
        set_ramp();
        pix[4] = 18'd100;
        res_ready = 1'b0;
        send_window(0);
        for (int k = 0; k < 20 && !res_valid; k++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid", res_valid, 1);
            check("bp_data", res_data, sb[0].data);
            check("bp_px_ready", px_ready, 0);
            check("bp_busy", busy, 1);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        wait_drain();
        set_ramp();
        send_window(0);
        wait_drain();

        // reload at tap 0 beats a valid pixel
        reload = 1'b1;
        px_valid = 1'b1;
        px_data = 18'd5;
        @(negedge clk);
        check("reload_px_ready", px_ready, 0);
        @(posedge clk);
        #1;
        reload = 1'b0;
        px_valid = 1'b0;
        @(negedge clk);
        check("reload_w_ready", w_ready, 1);
        @(posedge clk);
        #1;
        set_all(2);
        for (int i = 0; i < NT; i++) load_one(i);
        send_window(0);
        wait_drain();

        // reset mid-window
        set_all(1);
        send_pixels(4, 0);
        check("mid_busy", busy, 1);
        #2;
        sclr = 1'b1;
        #1;
        check("mr_res_valid", res_valid, 0);
        check("mr_res_data", res_data, 0);
        check("mr_res_ovf", res_ovf, 0);
        check("mr_mac_abc", {mac_a, mac_b, mac_c}, 0);
        check("mr_px_ready", px_ready, 0);
        check("mr_w_ready", w_ready, 1);
        check("mr_busy", busy, 0);
        @(posedge clk);
        #1;
        sclr = 1'b0;
        for (int i = 0; i < NT - 1; i++) load_one(i);
        @(negedge clk);
        check("mr_px_ready_8w", px_ready, 0);
        @(posedge clk);
        #1;
        load_one(NT - 1);
        @(negedge clk);
        check("mr_px_ready_9w", px_ready, 1);
        check("mr_w_ready_9w", w_ready, 0);
        @(posedge clk);
        #1;
        send_window(0);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
